// File: rtl/contador_regressivo_pkg.sv
// Shared types and step constants for the board's up and down counters.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int INCR_1 = 1;
  localparam int INCR_3 = 3;

endpackage

// File: rtl/contador_regressivo_if.sv
// Control/status bundle of the down-counting timer; clk_2 and reset stay outside.
interface contador_regressivo_if #(
  parameter int NBITS_COUNT = 4
);
  import contador_pkg::*;

  logic                   load;
  logic [NBITS_COUNT-1:0] load_val;
  logic                   start;
  logic                   pause;
  logic                   stop;
  logic                   step_3;
  logic                   auto_reload;
  logic                   ack;
  logic [NBITS_COUNT-1:0] count;
  logic                   busy;
  logic                   done;
  logic                   expired;
  state_t                 dbg_state;

  // Commands are levels sampled on every rising clk_2 edge; no ready/valid
  // handshake: a command takes effect only in the states that accept it.
  modport master (
    output load, load_val, start, pause, stop, step_3, auto_reload, ack,
    input  count, busy, done, expired, dbg_state
  );

  modport slave (
    input  load, load_val, start, pause, stop, step_3, auto_reload, ack,
    output count, busy, done, expired, dbg_state
  );

endinterface

// File: rtl/contador_regressivo.sv
// Programmable down-counting timer with floor at zero, expiry pulse/flag
// and optional auto-reload for periodic operation.
module contador_regressivo #(
  parameter int NBITS_COUNT = 4,
  parameter int INCR_1      = contador_pkg::INCR_1,
  parameter int INCR_3      = contador_pkg::INCR_3
) (
  input  logic                  clk_2,
  input  logic                  reset,
  contador_regressivo_if.slave  bus
);
  import contador_pkg::*;

  state_t                 state_q, state_d;
  logic [NBITS_COUNT-1:0] count_q, count_d;
  logic [NBITS_COUNT-1:0] reload_q, reload_d;
  logic                   done_q, done_d;
  logic [NBITS_COUNT-1:0] step;

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    step     = bus.step_3 ? NBITS_COUNT'(INCR_3) : NBITS_COUNT'(INCR_1);

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          count_d  = bus.load_val;
          reload_d = bus.load_val;
        end else if (bus.start && (count_q != '0)) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.pause) begin
          state_d = PAUSED;
        end else if (count_q > step) begin
          count_d = count_q - step;
        end else begin
          // Terminal edge: the comparison above keeps the subtraction from wrapping.
          done_d = 1'b1;
          if (bus.auto_reload && (reload_q != '0)) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = EXPIRED;
          end
        end
      end

      PAUSED: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (!bus.pause) begin
          state_d = RUN;
        end
      end

      EXPIRED: begin
        count_d = '0;
        if (bus.load) begin
          state_d  = IDLE;
          count_d  = bus.load_val;
          reload_d = bus.load_val;
        end else if (bus.ack) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.count     = count_q;
  assign bus.done      = done_q;
  assign bus.expired   = (state_q == EXPIRED);
  assign bus.busy      = (state_q == RUN) || (state_q == PAUSED);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_contador_regressivo.sv
// Directed bench for contador_regressivo: countdown, fast step, auto-reload,
// pause/resume, asynchronous reset and ignored commands.
module tb_contador_regressivo;
  import contador_pkg::*;

  localparam int NB = 4;

  logic clk_2;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [NB-1:0] exp_q[$];

  contador_regressivo_if #(.NBITS_COUNT(NB)) bus ();

  contador_regressivo #(.NBITS_COUNT(NB)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / watchdog
  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  // checking
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_load(input int v);
    bus.load     = 1'b1;
    bus.load_val = NB'(v);
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // pops expected counts edge by edge; done must be low on all but the last
  task automatic run_expected(input string tag, input bit last_done);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_count"}, int'(bus.count), int'(exp_q.pop_front()));
      if (i != n - 1 || !last_done) check({tag, "_done_lo"}, int'(bus.done), 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.load = 0; bus.load_val = '0; bus.start = 0; bus.pause = 0;
    bus.stop = 0; bus.step_3 = 0; bus.auto_reload = 0; bus.ack = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_count",   int'(bus.count),     0);
    check("rst_state",   int'(bus.dbg_state), int'(IDLE));
    check("rst_busy",    int'(bus.busy),      0);
    check("rst_done",    int'(bus.done),      0);
    check("rst_expired", int'(bus.expired),   0);
    @(negedge clk_2);
    reset = 1'b1;
    tick();

    // countdown and expiry
    do_load(5);
    check("cd_loaded", int'(bus.count), 5);
    do_start();
    check("cd_start_count", int'(bus.count), 5);
    check("cd_busy", int'(bus.busy), 1);
    exp_q = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    run_expected("cd", 1'b1);
    check("cd_done_pulse", int'(bus.done),    1);
    check("cd_expired",    int'(bus.expired), 1);
    check("cd_busy_lo",    int'(bus.busy),    0);
    tick();
    check("cd_done_one_cycle", int'(bus.done),    0);
    check("cd_expired_held",   int'(bus.expired), 1);
    check("cd_count_floor",    int'(bus.count),   0);
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    check("cd_ack_state",   int'(bus.dbg_state), int'(IDLE));
    check("cd_ack_expired", int'(bus.expired),   0);

    // fast step with floor
    do_load(7);
    bus.step_3 = 1'b1;
    do_start();
    exp_q = '{4'd4, 4'd1, 4'd0};
    run_expected("fast", 1'b1);
    check("fast_done",    int'(bus.done),    1);
    check("fast_expired", int'(bus.expired), 1);
    tick();
    check("fast_no_wrap", int'(bus.count), 0);
    check("fast_done_lo", int'(bus.done),  0);
    bus.step_3 = 1'b0;
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;

    // auto-reload
    do_load(3);
    bus.auto_reload = 1'b1;
    do_start();
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      check("ar_count",   int'(bus.count),   (cyc % 3 == 2) ? 3 : 2 - (cyc % 3));
      check("ar_done",    int'(bus.done),    (cyc % 3 == 2) ? 1 : 0);
      check("ar_expired", int'(bus.expired), 0);
    end
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    check("ar_stop_state", int'(bus.dbg_state), int'(IDLE));
    check("ar_stop_count", int'(bus.count),     3);
    check("ar_stop_busy",  int'(bus.busy),      0);
    bus.auto_reload = 1'b0;

    // pause / resume, then load ignored in RUN
    do_load(9);
    do_start();
    exp_q = '{4'd8, 4'd7, 4'd6};
    run_expected("pz", 1'b0);
    bus.pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("pz_hold_count", int'(bus.count),     6);
      check("pz_hold_busy",  int'(bus.busy),      1);
      check("pz_hold_state", int'(bus.dbg_state), int'(PAUSED));
    end
    bus.pause = 1'b0;
    tick();
    check("pz_resume_count", int'(bus.count),     6);
    check("pz_resume_state", int'(bus.dbg_state), int'(RUN));
    tick();
    check("pz_after_5", int'(bus.count), 5);
    bus.load = 1'b1; bus.load_val = 4'd12;
    tick();
    bus.load = 1'b0;
    check("run_load_ignored", int'(bus.count), 4);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    check("pz_stop_count", int'(bus.count), 4);

    // asynchronous reset mid-run
    do_load(5);
    do_start();
    exp_q = '{4'd4, 4'd3};
    run_expected("ar_rst", 1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_count",   int'(bus.count),   0);
    check("arst_busy",    int'(bus.busy),    0);
    check("arst_done",    int'(bus.done),    0);
    check("arst_expired", int'(bus.expired), 0);
    #1 reset = 1'b1;
    tick();
    check("arst_idle_state", int'(bus.dbg_state), int'(IDLE));
    check("arst_idle_count", int'(bus.count),     0);

    // start with count 0 ignored
    do_load(0);
    do_start();
    check("zero_start_state", int'(bus.dbg_state), int'(IDLE));
    check("zero_start_busy",  int'(bus.busy),      0);

    // load+start together: load wins
    bus.load = 1'b1; bus.load_val = 4'd2; bus.start = 1'b1;
    tick();
    bus.load = 1'b0; bus.start = 1'b0;
    check("ls_state", int'(bus.dbg_state), int'(IDLE));
    check("ls_count", int'(bus.count),     2);

    // EXPIRED: start ignored, then load+ack behaves as load
    do_start();
    exp_q = '{4'd1, 4'd0};
    run_expected("ex", 1'b1);
    check("ex_expired", int'(bus.expired), 1);
    do_start();
    check("ex_start_ignored", int'(bus.dbg_state), int'(EXPIRED));
    bus.load = 1'b1; bus.load_val = 4'd8; bus.ack = 1'b1;
    tick();
    bus.load = 1'b0; bus.ack = 1'b0;
    check("ex_la_state",   int'(bus.dbg_state), int'(IDLE));
    check("ex_la_count",   int'(bus.count),     8);
    check("ex_la_expired", int'(bus.expired),   0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
